// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the Minisys-1A external-interrupt front end.
package minisys_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    localparam logic [4:0] EXC_INT = 5'b00000;
    localparam int         IRQ_MAX = 8;

    // Fixed-priority encoder: lowest set index wins, zero when nothing is set.
    function automatic logic [2:0] prio_enc(input logic [IRQ_MAX-1:0] vec);
        logic [2:0] id_v;
        id_v = 3'd0;
        for (int i = IRQ_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id_v = 3'(i);
            end
        end
        return id_v;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Device/CP0 side signal bundle of the interrupt front end.
interface int_ctrl_if #(
    parameter int N_IRQ = 6
);
    logic [N_IRQ-1:0] irq_in;
    logic [N_IRQ-1:0] irq_mask;
    logic             ie;
    logic             int_ack;
    logic             eret;
    logic             int_req;
    logic [2:0]       int_id;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] lost;

    modport master (
        output irq_in, irq_mask, ie, int_ack, eret,
        input  int_req, int_id, pending, lost
    );

    modport slave (
        input  irq_in, irq_mask, ie, int_ack, eret,
        output int_req, int_id, pending, lost
    );
endinterface

// File: rtl/int_ctrl_irq_sync_edge.sv
// One interrupt line: multi-flop synchronizer followed by a registered rising-edge detector.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic edge_r
);
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;

    // Synchronizer shift chain, delayed copy and edge flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r   <= '0;
            sync_d_r <= 1'b0;
            edge_r   <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], d};
            sync_d_r <= sync_r[SYNC_STAGES-1];
            edge_r   <= sync_r[SYNC_STAGES-1] & ~sync_d_r;
        end
    end
endmodule

// File: rtl/int_ctrl.sv
// Interrupt front end ahead of CP0: edge capture, pending/lost bits, masking, priority, request FSM.
module int_ctrl
    import minisys_int_pkg::*;
#(
    parameter int N_IRQ       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    int_ctrl_if.slave   bus
);
    logic [N_IRQ-1:0]   edge_s;
    logic [N_IRQ-1:0]   pending_r;
    logic [N_IRQ-1:0]   lost_r;
    logic [N_IRQ-1:0]   clr_s;
    logic [IRQ_MAX-1:0] eligible_s;
    logic [2:0]         winner_s;
    logic [2:0]         int_id_r;
    logic               int_req_r;
    logic               ack_take_s;
    int_state_t         state_r;
    int_state_t         state_nxt_s;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .d      (bus.irq_in[g]),
            .edge_r (edge_s[g])
        );
    end

    assign ack_take_s = (state_r == REQ) && bus.int_ack;
    assign eligible_s = IRQ_MAX'(pending_r & bus.irq_mask);
    assign winner_s   = prio_enc(eligible_s);

    // Clear mask for the line CP0 just accepted; acks outside REQ touch nothing.
    always_comb begin
        clr_s = '0;
        if (ack_take_s) begin
            clr_s = N_IRQ'(1) << int_id_r;
        end else begin
            clr_s = '0;
        end
    end

    // Pending and lost bits: clear first, then a fresh edge sets again.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= '0;
            lost_r    <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | edge_s;
            lost_r    <= lost_r | (edge_s & pending_r & ~clr_s);
        end
    end

    // Next-state logic; ack has priority over a simultaneous eret.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ie && (eligible_s != '0)) state_nxt_s = REQ;
                else                              state_nxt_s = IDLE;
            end
            REQ: begin
                if (bus.int_ack)  state_nxt_s = SERVICE;
                else if (!bus.ie) state_nxt_s = IDLE;
                else              state_nxt_s = REQ;
            end
            SERVICE: begin
                if (bus.eret) state_nxt_s = IDLE;
                else          state_nxt_s = SERVICE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, request and latched id; the id only moves on entry to REQ so it stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            int_req_r <= 1'b0;
            int_id_r  <= 3'd0;
        end else begin
            state_r   <= state_nxt_s;
            int_req_r <= (state_nxt_s == REQ);
            if ((state_r == IDLE) && (state_nxt_s == REQ)) begin
                int_id_r <= winner_s;
            end else begin
                int_id_r <= int_id_r;
            end
        end
    end

    assign bus.int_req = int_req_r;
    assign bus.int_id  = int_id_r;
    assign bus.pending = pending_r;
    assign bus.lost    = lost_r;
endmodule
